// File: rtl/llkid_key_loader.sv
`timescale 1ns/1ps
// LLKI discrete key interface initiator: fetches 64-bit key words from a synchronous
// key store, hands them to a TSS block under valid/ready, and reports a status code.
module llkid_key_loader #(
   parameter int MAX_WORDS = 32,
   parameter int ADDR_W    = 8,
   parameter int TIMEOUT   = 1024
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           cmd_valid,
   output logic                           cmd_ready,
   input  logic                           cmd_clear,
   input  logic [ADDR_W-1:0]              cmd_base_addr,
   input  logic [$clog2(MAX_WORDS+1)-1:0] cmd_num_words,
   output logic                           key_rd_en,
   output logic [ADDR_W-1:0]              key_rd_addr,
   input  logic [63:0]                    key_rd_data,
   output logic [63:0]                    llkid_key_data,
   output logic                           llkid_key_valid,
   input  logic                           llkid_key_ready,
   input  logic                           llkid_key_complete,
   output logic                           llkid_clear_key,
   input  logic                           llkid_clear_key_ack,
   output logic                           resp_valid,
   output logic [1:0]                     resp_status,
   output logic                           busy
);

   localparam int NW = $clog2(MAX_WORDS + 1);
   localparam int TW = $clog2(TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_CAPTURE, S_SEND, S_WAIT_CPL, S_CLEAR, S_RESP
   } state_t;

   typedef enum logic [1:0] {
      ST_OK = 2'b00, ST_TMO = 2'b01, ST_LEN = 2'b10, ST_PROTO = 2'b11
   } status_t;

   state_t              state_q;
   status_t             resp_status_q;
   logic [ADDR_W-1:0]   base_q;
   logic [NW-1:0]       num_q;
   logic [NW-1:0]       idx_q;
   logic [NW-1:0]       idx_d;
   logic [TW-1:0]       tmo_q;
   logic [TW-1:0]       tmo_d;
   logic                cmd_ready_q;
   logic                busy_q;
   logic                rd_en_q;
   logic [ADDR_W-1:0]   rd_addr_q;
   logic [63:0]         key_data_q;
   logic                key_valid_q;
   logic                clear_q;
   logic                resp_valid_q;
   logic                last_w;
   logic                tmo_exp;
   logic                cmd_bad;

   always_comb begin
      idx_d   = idx_q + 1'b1;
      tmo_d   = tmo_q + 1'b1;
      last_w  = (idx_q == num_q - 1'b1);
      tmo_exp = (tmo_q == TW'(TIMEOUT - 1));
      cmd_bad = (cmd_num_words == '0) || (cmd_num_words > NW'(MAX_WORDS));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         resp_status_q <= ST_OK;
         base_q        <= '0;
         num_q         <= '0;
         idx_q         <= '0;
         tmo_q         <= '0;
         cmd_ready_q   <= 1'b1;
         busy_q        <= 1'b0;
         rd_en_q       <= 1'b0;
         rd_addr_q     <= '0;
         key_data_q    <= '0;
         key_valid_q   <= 1'b0;
         clear_q       <= 1'b0;
         resp_valid_q  <= 1'b0;
      end else begin
         rd_en_q      <= 1'b0;
         resp_valid_q <= 1'b0;
         tmo_q        <= tmo_d;
         case (state_q)
            S_IDLE: begin
               if (cmd_valid && cmd_ready_q) begin
                  cmd_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  base_q      <= cmd_base_addr;
                  num_q       <= cmd_num_words;
                  idx_q       <= '0;
                  if (cmd_clear) begin
                     clear_q <= 1'b1;
                     tmo_q   <= '0;
                     state_q <= S_CLEAR;
                  end else if (cmd_bad) begin
                     resp_valid_q  <= 1'b1;
                     resp_status_q <= ST_LEN;
                     state_q       <= S_RESP;
                  end else begin
                     rd_en_q   <= 1'b1;
                     rd_addr_q <= cmd_base_addr;
                     state_q   <= S_FETCH;
                  end
               end
            end
            S_FETCH, S_CAPTURE: begin
               if (llkid_key_complete) begin
                  resp_valid_q  <= 1'b1;
                  resp_status_q <= ST_PROTO;
                  state_q       <= S_RESP;
               end else if (state_q == S_FETCH) begin
                  state_q <= S_CAPTURE;
               end else begin
                  key_data_q  <= key_rd_data;
                  key_valid_q <= 1'b1;
                  tmo_q       <= '0;
                  state_q     <= S_SEND;
               end
            end
            S_SEND: begin
               // Last-word transfer outranks complete; any other complete aborts.
               if (llkid_key_ready && last_w) begin
                  key_valid_q <= 1'b0;
                  tmo_q       <= '0;
                  state_q     <= S_WAIT_CPL;
               end else if (llkid_key_complete) begin
                  key_valid_q   <= 1'b0;
                  resp_valid_q  <= 1'b1;
                  resp_status_q <= ST_PROTO;
                  state_q       <= S_RESP;
               end else if (llkid_key_ready) begin
                  key_valid_q <= 1'b0;
                  idx_q       <= idx_d;
                  rd_en_q     <= 1'b1;
                  rd_addr_q   <= base_q + ADDR_W'(idx_d);
                  state_q     <= S_FETCH;
               end else if (tmo_exp) begin
                  key_valid_q   <= 1'b0;
                  resp_valid_q  <= 1'b1;
                  resp_status_q <= ST_TMO;
                  state_q       <= S_RESP;
               end
            end
            S_WAIT_CPL: begin
               if (llkid_key_complete || tmo_exp) begin
                  resp_valid_q  <= 1'b1;
                  resp_status_q <= llkid_key_complete ? ST_OK : ST_TMO;
                  state_q       <= S_RESP;
               end
            end
            S_CLEAR: begin
               if (llkid_clear_key_ack || tmo_exp) begin
                  clear_q       <= 1'b0;
                  resp_valid_q  <= 1'b1;
                  resp_status_q <= llkid_clear_key_ack ? ST_OK : ST_TMO;
                  state_q       <= S_RESP;
               end
            end
            S_RESP: begin
               cmd_ready_q <= 1'b1;
               busy_q      <= 1'b0;
               state_q     <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign cmd_ready       = cmd_ready_q;
   assign busy            = busy_q;
   assign key_rd_en       = rd_en_q;
   assign key_rd_addr     = rd_addr_q;
   assign llkid_key_data  = key_data_q;
   assign llkid_key_valid = key_valid_q;
   assign llkid_clear_key = clear_q;
   assign resp_valid      = resp_valid_q;
   assign resp_status     = resp_status_q;

endmodule

// File: tb/tb_llkid_key_loader.sv
`timescale 1ns/1ps
// Scoreboard bench for llkid_key_loader: behavioural key store and TSS responder,
// expectations derived per command from the transfer/timeout/abort rules.
module tb_llkid_key_loader;

   localparam int MAXW = 32;
   localparam int AW   = 8;
   localparam int TMO  = 16;
   localparam int NW   = $clog2(MAXW + 1);

   logic          clk;
   logic          rst;
   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_clear;
   logic [AW-1:0] cmd_base_addr;
   logic [NW-1:0] cmd_num_words;
   logic          key_rd_en;
   logic [AW-1:0] key_rd_addr;
   logic [63:0]   key_rd_data;
   logic [63:0]   llkid_key_data;
   logic          llkid_key_valid;
   logic          llkid_key_ready;
   logic          llkid_key_complete;
   logic          llkid_clear_key;
   logic          llkid_clear_key_ack;
   logic          resp_valid;
   logic [1:0]    resp_status;
   logic          busy;

   llkid_key_loader #(.MAX_WORDS(MAXW), .ADDR_W(AW), .TIMEOUT(TMO)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .cmd_valid           (cmd_valid),
      .cmd_ready           (cmd_ready),
      .cmd_clear           (cmd_clear),
      .cmd_base_addr       (cmd_base_addr),
      .cmd_num_words       (cmd_num_words),
      .key_rd_en           (key_rd_en),
      .key_rd_addr         (key_rd_addr),
      .key_rd_data         (key_rd_data),
      .llkid_key_data      (llkid_key_data),
      .llkid_key_valid     (llkid_key_valid),
      .llkid_key_ready     (llkid_key_ready),
      .llkid_key_complete  (llkid_key_complete),
      .llkid_clear_key     (llkid_clear_key),
      .llkid_clear_key_ack (llkid_clear_key_ack),
      .resp_valid          (resp_valid),
      .resp_status         (resp_status),
      .busy                (busy)
   );

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int n_resp = 0;
   int resp_cyc = 0;

   logic [63:0]   mem [256];
   logic [AW-1:0] q_addr [$];
   logic [63:0]   q_data [$];
   int            q_run  [$];
   int            q_clr  [$];
   logic [1:0]    q_resp [$];

   // TSS behaviour knobs for the command in flight
   int t_rdly  = 0;
   int t_abort = -1;
   int t_cpl   = 0;
   int t_ack   = 0;
   int t_num   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (key_rd_en) key_rd_data <= mem[key_rd_addr];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic unexp(input string name, input logic [63:0] act);
      checks++;
      errors++;
      $display("FAIL %s: got %h while nothing was expected", name, act);
   endtask

   // TSS responder: drives ready/complete/ack shortly after each rising edge
   initial begin
      int vcnt, ccnt, wcnt, wc;
      bit started;
      llkid_key_ready = 1'b0; llkid_key_complete = 1'b0; llkid_clear_key_ack = 1'b0;
      vcnt = 0; ccnt = 0; wcnt = 0; wc = 0; started = 0;
      forever begin
         @(posedge clk); #1;
         if (rst || !busy) begin
            llkid_key_ready = 1'($urandom);
            llkid_key_complete = 1'b0; llkid_clear_key_ack = 1'b0;
            vcnt = 0; ccnt = 0; wcnt = 0; wc = 0; started = 0;
         end else begin
            llkid_clear_key_ack = 1'b0;
            if (llkid_clear_key) begin
               llkid_clear_key_ack = (ccnt == t_ack);
               ccnt++;
            end else ccnt = 0;
            if (llkid_key_valid) begin
               if (wcnt == t_abort) begin
                  llkid_key_ready = 1'b0;
                  llkid_key_complete = (vcnt == 0);
               end else begin
                  llkid_key_ready = (vcnt >= t_rdly);
                  llkid_key_complete = 1'b0;
                  if (llkid_key_ready) begin
                     wcnt++;
                     if (wcnt == t_num) started = 1;
                  end
               end
               vcnt++;
            end else begin
               llkid_key_ready = 1'($urandom);
               vcnt = 0;
               llkid_key_complete = 1'b0;
               if (started) begin
                  llkid_key_complete = (wc >= t_cpl);
                  wc++;
               end
            end
         end
      end
   end

   // Monitor: pops expectations whenever the DUT presents an observable event
   initial begin
      int vrun, crun;
      logic [63:0] vdata0;
      bit vstable;
      vrun = 0; crun = 0; vstable = 1; vdata0 = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            vrun = 0; crun = 0; vstable = 1;
         end else begin
            chk("ready_vs_busy", 64'(cmd_ready), 64'(!busy));
            if (key_rd_en) begin
               if (q_addr.size() == 0) unexp("rd_unexpected", 64'(key_rd_addr));
               else chk("rd_addr", 64'(key_rd_addr), 64'(q_addr.pop_front()));
            end
            if (llkid_key_valid) begin
               if (vrun == 0) vdata0 = llkid_key_data;
               else if (llkid_key_data !== vdata0) vstable = 0;
               vrun++;
               if (llkid_key_ready) begin
                  if (q_data.size() == 0) unexp("xfer_unexpected", llkid_key_data);
                  else chk("xfer_data", llkid_key_data, q_data.pop_front());
               end
            end else if (vrun != 0) begin
               if (q_run.size() == 0) unexp("valid_unexpected", 64'(vrun));
               else chk("valid_len", 64'(vrun), 64'(q_run.pop_front()));
               chk("data_stable", 64'(vstable), 64'(1));
               vrun = 0; vstable = 1;
            end
            if (llkid_clear_key) crun++;
            else if (crun != 0) begin
               if (q_clr.size() == 0) unexp("clear_unexpected", 64'(crun));
               else chk("clear_len", 64'(crun), 64'(q_clr.pop_front()));
               crun = 0;
            end
            if (resp_valid) begin
               n_resp++;
               resp_cyc = cyc;
               if (q_resp.size() == 0) unexp("resp_unexpected", 64'(resp_status));
               else chk("resp_status", 64'(resp_status), 64'(q_resp.pop_front()));
            end
         end
      end
   end

   task automatic run_cmd(input bit clr, input logic [AW-1:0] base, input int num,
                          input int rdly, input int abort_k, input int cpl,
                          input int ack, input int hold);
      int er, target, cmd_cyc, i;
      bit bad;
      @(posedge clk); #1;
      chk("cmd_ready_idle", 64'(cmd_ready), 64'(1));
      bad = !clr && (num == 0 || num > MAXW);
      er = -1;
      if (clr) begin
         if (ack <= TMO - 1) begin er = 0; q_clr.push_back(ack + 1); end
         else begin er = 1; q_clr.push_back(TMO); end
      end else if (bad) begin
         er = 2;
      end else begin
         for (i = 0; i < num; i++) begin
            logic [AW-1:0] a;
            a = AW'(int'(base) + i);
            q_addr.push_back(a);
            if (i == abort_k) begin q_run.push_back(1); er = 3; break; end
            if (rdly > TMO - 1) begin q_run.push_back(TMO); er = 1; break; end
            q_run.push_back(rdly + 1);
            q_data.push_back(mem[a]);
         end
         if (er < 0) er = (cpl <= TMO - 1) ? 0 : 1;
      end
      q_resp.push_back(2'(er));
      t_rdly = rdly; t_abort = (abort_k < num) ? abort_k : -1;
      t_cpl = cpl; t_ack = ack; t_num = num;
      target = n_resp + 1;
      cmd_cyc = cyc;
      cmd_clear = clr; cmd_base_addr = base; cmd_num_words = NW'(num); cmd_valid = 1'b1;
      @(posedge clk); #1;
      if (hold > 0) begin
         cmd_clear = !clr; cmd_num_words = NW'($urandom_range(1, MAXW));
         repeat (hold) begin @(posedge clk); #1; end
      end
      cmd_valid = 1'b0;
      for (i = 0; i < 3000 && n_resp < target; i++) @(posedge clk);
      chk("resp_arrived", 64'(n_resp >= target), 64'(1));
      if (bad) chk("len_resp_latency", 64'((resp_cyc - cmd_cyc) inside {1, 2}), 64'(1));
      #1;
      chk("queues_drained", 64'(q_addr.size() + q_data.size() + q_run.size() + q_clr.size() + q_resp.size()), 64'(0));
   endtask

   initial begin
      int nr, w;
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int nr, w, kind, num, rdly, abk, cpl, ack, hold;
      rst = 1'b1; cmd_valid = 1'b0; cmd_clear = 1'b0; cmd_base_addr = '0; cmd_num_words = '0;
      key_rd_data = '0;
      for (int i = 0; i < 256; i++) mem[i] = {$urandom(), $urandom()};
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_valid", 64'(llkid_key_valid), 64'(0));
      chk("rst_rd_en", 64'(key_rd_en), 64'(0));
      chk("rst_clear", 64'(llkid_clear_key), 64'(0));
      chk("rst_resp", {61'(resp_valid), resp_status, 1'b0}, 64'(0));
      chk("rst_key_data", llkid_key_data, 64'(0));
      @(negedge clk); #2 rst = 1'b0;

      for (int i = 0; i < 4; i++) mem[16 + i] = 64'hA5A5_0000_0000_00A0 + 64'(i);
      run_cmd(0, 8'h10, 4, 2, -1, 0, 0, 2);
      run_cmd(0, 8'h00, 0, 0, -1, 0, 0, 0);
      run_cmd(0, 8'h33, MAXW + 1, 0, -1, 0, 0, 0);
      run_cmd(0, 8'h70, 1, 1000, -1, 0, 0, 0);
      run_cmd(1, 8'h00, 0, 0, -1, 0, 5, 0);
      run_cmd(0, 8'h40, 4, 1, 1, 0, 0, 0);
      run_cmd(0, 8'hFE, 3, 0, -1, 2, 0, 0);
      run_cmd(0, 8'h80, MAXW, 0, -1, 0, 0, 0);
      run_cmd(0, 8'h20, 2, TMO - 1, -1, TMO - 1, 0, 0);
      run_cmd(0, 8'h30, 1, 0, -1, TMO, 0, 0);
      run_cmd(1, 8'h00, 0, 0, -1, 0, TMO - 1, 0);
      run_cmd(1, 8'h00, 0, 0, -1, 0, TMO, 0);

      // asynchronous reset in the middle of a word transfer
      @(posedge clk); #1;
      t_rdly = 1000; t_abort = -1; t_cpl = 0; t_num = 3;
      q_addr.push_back(8'h55);
      cmd_clear = 1'b0; cmd_base_addr = 8'h55; cmd_num_words = NW'(3); cmd_valid = 1'b1;
      @(posedge clk); #1 cmd_valid = 1'b0;
      w = 0;
      while (!llkid_key_valid && w < 20) begin @(posedge clk); #1; w++; end
      chk("rst_setup_valid", 64'(llkid_key_valid), 64'(1));
      repeat (4) @(posedge clk);
      @(negedge clk); #2 rst = 1'b1; #1;
      chk("rst_mid_valid", 64'(llkid_key_valid), 64'(0));
      chk("rst_mid_busy", 64'(busy), 64'(0));
      nr = n_resp;
      @(negedge clk); @(negedge clk); #2 rst = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      chk("rst_no_resp", 64'(n_resp), 64'(nr));
      chk("rst_after_ready", 64'(cmd_ready), 64'(1));
      chk("rst_queues", 64'(q_addr.size() + q_resp.size()), 64'(0));

      for (int n = 0; n < 60; n++) begin
         kind = $urandom_range(0, 9);
         w = $urandom_range(0, 9);
         rdly = (w < 6) ? $urandom_range(0, 3) : (w == 6) ? TMO - 1 : (w == 7) ? TMO : 0;
         num = ($urandom_range(0, 9) == 0) ? MAXW : $urandom_range(1, 6);
         abk = ($urandom_range(0, 6) == 0) ? $urandom_range(0, num - 1) : -1;
         w = $urandom_range(0, 7);
         cpl = (w < 5) ? $urandom_range(0, 3) : (w == 5) ? TMO - 1 : (w == 6) ? TMO : 0;
         w = $urandom_range(0, 7);
         ack = (w < 6) ? $urandom_range(0, 6) : (w == 6) ? TMO - 1 : TMO;
         hold = (num >= 2) ? $urandom_range(0, 2) : 0;
         if (kind < 2) run_cmd(1, 8'($urandom), 0, 0, -1, 0, ack, 0);
         else if (kind == 2)
            run_cmd(0, 8'($urandom), ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(MAXW + 1, 63), 0, -1, 0, 0, 0);
         else run_cmd(0, 8'($urandom), num, rdly, abk, cpl, 0, hold);
      end

      repeat (2) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/llkid_key_loader.md
Name: llkid_key_loader

Overview:
- Initiator end of the LLKI discrete key interface; drives key words into a TSS block's llkid_* inputs.
- The TSS block latches the words into its key register for a locked core.
- Accepts load or clear commands from the LLKI control logic.
- Fetches 64-bit key words from a synchronous key store, transfers them one at a time under valid/ready, then confirms key_complete or clear_key_ack and reports status.

Parameters:
- MAX_WORDS, 32, maximum key words per load command.
- ADDR_W, 8, key store address width.
- TIMEOUT, 1024, cycles allowed per handshake wait before abort; must be ≥2.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_clear  in  1  1 = clear-key command, 0 = load command.
- cmd_base_addr  in  ADDR_W  first key store address (load only).
- cmd_num_words  in  $clog2(MAX_WORDS+1)  words to send (load only).
- key_rd_en  out  1  key store read strobe.
- key_rd_addr  out  ADDR_W  key store read address.
- key_rd_data  in  64  read data, valid the cycle after key_rd_en.
- llkid_key_data  out  64  key word to TSS.
- llkid_key_valid  out  1  key word valid.
- llkid_key_ready  in  1  TSS accepted word.
- llkid_key_complete  in  1  TSS reports full key loaded (level).
- llkid_clear_key  out  1  clear request.
- llkid_clear_key_ack  in  1  TSS clear acknowledge.
- resp_valid  out  1  one-cycle response pulse.
- resp_status  out  2  00 ok, 01 timeout, 10 bad length, 11 protocol error.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, active high):
  - State = IDLE; all outputs 0 except cmd_ready = 1.
  - Reset mid-operation drops llkid_key_valid / llkid_clear_key immediately; no response is issued.
- States: IDLE, FETCH, CAPTURE, SEND, WAIT_CPL, CLEAR, RESP.
- IDLE:
  - Command is accepted on cmd_valid && cmd_ready; operands are registered and word index idx = 0.
  - cmd_clear = 1 → CLEAR.
  - Load with cmd_num_words == 0 or > MAX_WORDS → RESP with status 10; no LLKI or key store activity.
  - Otherwise → FETCH.
- FETCH: key_rd_en = 1 for exactly one cycle, key_rd_addr = base + idx (mod 2^ADDR_W wrap) → CAPTURE.
- CAPTURE: register key_rd_data into llkid_key_data, assert llkid_key_valid → SEND.
- SEND:
  - llkid_key_valid and llkid_key_data are held stable until llkid_key_ready is sampled high.
  - Transfer occurs on valid && ready. llkid_key_valid is 0 the following cycle.
  - If idx == num-1 → WAIT_CPL; else idx++ → FETCH.
  - Minimum 3 cycles per word.
- llkid_key_ready sampled while llkid_key_valid = 0: ignored.
- llkid_key_complete high in FETCH/CAPTURE/SEND before the last word transfers:
  - Abort; drop valid → RESP with status 11.
- WAIT_CPL:
  - llkid_key_complete high → RESP with status 00. This includes the case where complete is already high on the cycle of entry.
- CLEAR:
  - llkid_clear_key = 1 held until llkid_clear_key_ack is sampled high.
  - Deassert the next cycle → RESP with status 00.
- Timeout counter:
  - Cleared on entering SEND, WAIT_CPL or CLEAR; increments each cycle in those states.
  - Reaching TIMEOUT-1 without the awaited event → drop valid/clear → RESP with status 01.
  - The awaited event on the same cycle as expiry wins (no timeout).
- RESP: resp_valid = 1 with resp_status for one cycle → IDLE. resp_status holds its value until the next response.
- New commands are never accepted while busy.

Test Plan:
- Load base=0x10, num=4; store words A0..A3; TSS asserts ready 2 cycles after each valid, then complete → reads at 0x10..0x13, four transfers with data A0..A3 in order, valid low between words, resp 00.
- Load num=0, and separately num=MAX_WORDS+1 → resp_valid next-but-one cycle with status 10; key_rd_en and llkid_key_valid never assert.
- TSS never asserts ready, TIMEOUT=16 → valid held 16 cycles with stable data, then dropped; resp 01.
- Clear command, ack after 5 cycles → clear_key high exactly until ack sample, low next cycle; resp 00.
- complete pulsed during word 2 of 4 → valid dropped, resp 11. Separately, base=0xFE, num=3 → addresses 0xFE, 0xFF, 0x00.
- Async reset asserted mid-SEND → valid low immediately, cmd_ready=1 after release, no resp_valid.
